fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage directly upstream of the instruction memory. It owns the program counter, issues word-addressed read requests to the memory, and captures each returned instruction with its PC into a 2-entry buffer. The buffer feeds decode over a valid/ready handshake. Branch/jump redirects flush the buffer, discard any in-flight response, and restart fetch at the new PC.

## Interface
- RESET_PC, 32'h0000_0000, word address fetched first after reset.
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- imem_addr  out  32  word address to instruction memory; always equals current PC.
- imem_rd_en  out  1  read request; memory samples addr/rd_en on posedge and returns data one cycle later.
- imem_instr  in  32  instruction returned by memory.
- imem_ready  in  1  high for exactly the cycle after an accepted rd_en; imem_instr valid in that cycle.
- redirect  in  1  one-cycle pulse: flush and restart fetch at redirect_pc.
- redirect_pc  in  32  target word address, sampled when redirect=1.
- dec_valid  out  1  buffer head holds a valid instruction.
- dec_instr  out  32  instruction at buffer head.
- dec_pc  out  32  word address of dec_instr.
- dec_ready  in  1  decode accepts the head this cycle (transfer = dec_valid & dec_ready).

## Operation
- State: pc[31:0]; buffer of 2 entries {instr, pc}, with rd/wr pointers (1 bit each) and count (0..2); inflight (1 bit, registered copy of imem_rd_en); req_pc (PC of the in-flight request).
- Reset values: pc=RESET_PC, count=0, pointers=0, inflight=0, buffer entries=0. Outputs: imem_rd_en=0, imem_addr=RESET_PC, dec_valid=0, dec_instr=0, dec_pc=0.
- pop = dec_valid & dec_ready & !redirect (redirect takes precedence; see below).
- Issue rule (combinational): imem_rd_en = !rst & !redirect & ((count + inflight - pop) <= 1). A response therefore always has a free slot.
- On issue: req_pc <= pc and pc <= pc + 1 (mod 2^32; 32'hFFFF_FFFF wraps to 0). The block does no range check against memory depth.
- Capture: if imem_ready & inflight & !redirect, write {imem_instr, req_pc} at wr pointer.
- Count: count += push - pop. Simultaneous push and pop leaves count unchanged.
- dec_valid = (count != 0). dec_instr/dec_pc = entry at rd pointer.
- Redirect cycle:
  - pc <= redirect_pc; count <= 0; pointers <= 0; inflight <= 0.
  - Any imem_ready response arriving in the same cycle is dropped.
  - imem_rd_en=0 that cycle. Fetch from redirect_pc is issued the following cycle.
  - A dec_valid&dec_ready handshake in the redirect cycle counts as consumed by decode; the fetch unit discards all buffered entries regardless.
- imem_ready with inflight=0 is ignored. A stale hold value from memory is never captured.
- Reset mid-operation: all state returns to reset values on the next posedge. In-flight responses are dropped via inflight=0.

## Timing
- Cycle 0 is the first cycle with rst=0:
  - Cycle 0: imem_rd_en=1, imem_addr=RESET_PC.
  - Cycle 1: imem_ready=1 with the returned instruction.
  - Cycle 2: dec_valid=1, dec_pc=RESET_PC.
- Fetch-to-decode latency: 2 cycles. Steady state with dec_ready held high: one instruction per cycle, consecutive PCs.
- Redirect at cycle R: imem_rd_en=0 at R, request for redirect_pc at R+1, dec_valid=1 with dec_pc=redirect_pc at R+3. Penalty: 3 cycles after redirect.
- dec_ready low: buffer fills to 2, then imem_rd_en drops. With count=2 and inflight=0, no requests are issued. When dec_ready rises, a request is issued in that same cycle.
- Outputs dec_* come from registers/buffer only. imem_rd_en depends combinationally on dec_ready and redirect.

## Test plan
- Reset, RESET_PC=0, dec_ready=1, memory word n holds n+32'h100 -> dec_valid from cycle 2; dec_pc 0,1,2,3… and dec_instr 0x100,0x101,… on consecutive cycles, no gaps.
- Steady stream, then dec_ready=0 for 5 cycles -> count reaches 2, imem_rd_en=0 while stalled; on release, PCs resume in order with no skips or duplicates.
- Redirect to 32'h40 in the same cycle as an imem_ready response -> that response is discarded; next dec_pc = 0x40 exactly 3 cycles after redirect; no pre-redirect instruction appears afterwards.
- Redirect to 32'hFFFF_FFFF -> dec_pc sequence FFFF_FFFF, 0000_0000, 0000_0001 (wrap).
- Assert rst for one cycle mid-stream with a full buffer and a request in flight -> dec_valid=0 and imem_rd_en=0 during reset; fetch restarts at RESET_PC; no stale instruction is delivered.
- Random dec_ready (50%) and random redirects over 10k cycles, checked against a reference PC model -> every delivered {pc, instr} matches memory[pc]; sequence is contiguous between redirects; count never exceeds 2.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory request/response, redirect and decode handshake.
// The master modport is the fetch unit; the slave side is memory, branch unit and decode.
interface fetch_unit_if;
    logic [31:0] imem_addr;
    logic        imem_rd_en;
    logic [31:0] imem_instr;
    logic        imem_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        dec_ready;

    modport master (
        output imem_addr, imem_rd_en, dec_valid, dec_instr, dec_pc,
        input  imem_instr, imem_ready, redirect, redirect_pc, dec_ready
    );

    modport slave (
        input  imem_addr, imem_rd_en, dec_valid, dec_instr, dec_pc,
        output imem_instr, imem_ready, redirect, redirect_pc, dec_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues one-cycle-latency memory reads and buffers
// up to two {instr, pc} entries for decode; redirects flush and restart fetch.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master fu_io
);

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      req_pc_q, req_pc_d;
    logic [1:0][31:0] buf_instr_q, buf_instr_d;
    logic [1:0][31:0] buf_pc_q, buf_pc_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             inflight_q, inflight_d;

    logic             pop_s;
    logic             push_s;
    logic             issue_s;
    logic [2:0]       occ_s;

    // Handshake qualifiers and the issue decision.
    always_comb begin
        pop_s   = (count_q != 2'd0) & fu_io.dec_ready & ~fu_io.redirect;
        push_s  = fu_io.imem_ready & inflight_q & ~fu_io.redirect;
        // Slots committed after this cycle; a new request needs one left free for its response.
        occ_s   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop_s};
        issue_s = ~rst & ~fu_io.redirect & (occ_s <= 3'd1);
    end

    // Next-state for PC, request tracking and the two-entry buffer.
    always_comb begin
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        inflight_d  = inflight_q;

        if (fu_io.redirect) begin
            pc_d       = fu_io.redirect_pc;
            rd_ptr_d   = 1'b0;
            wr_ptr_d   = 1'b0;
            count_d    = 2'd0;
            inflight_d = 1'b0;
        end else begin
            inflight_d = issue_s;
            if (issue_s) begin
                req_pc_d = pc_q;
                pc_d     = pc_q + 32'd1;
            end else begin
                req_pc_d = req_pc_q;
                pc_d     = pc_q;
            end
            if (push_s) begin
                buf_instr_d[wr_ptr_q] = fu_io.imem_instr;
                buf_pc_d[wr_ptr_q]    = req_pc_q;
                wr_ptr_d              = ~wr_ptr_q;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = ~rd_ptr_q;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + {1'b0, push_s} - {1'b0, pop_s};
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            req_pc_q    <= 32'h0000_0000;
            buf_instr_q <= '{default: 32'h0000_0000};
            buf_pc_q    <= '{default: 32'h0000_0000};
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            inflight_q  <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            inflight_q  <= inflight_d;
        end
    end

    assign fu_io.imem_addr  = pc_q;
    assign fu_io.imem_rd_en = issue_s;
    assign fu_io.dec_valid  = (count_q != 2'd0);
    assign fu_io.dec_instr  = buf_instr_q[rd_ptr_q];
    assign fu_io.dec_pc     = buf_pc_q[rd_ptr_q];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle-exact vector table for the corner cases, then a long random
// phase; a PC-sequence scoreboard checks every delivered instruction throughout.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;

    fetch_unit_if fu_if ();

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .rst   (rst),
        .fu_io (fu_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        dr;
        logic        rd;
        logic [31:0] rpc;
        logic        spur;
        logic        cdv;
        logic        cz;
        logic        erd;
        logic [31:0] ea;
        logic        edv;
        logic [31:0] ep;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          delivered = 0;
    logic        mem_pend;
    logic [31:0] mem_data;
    logic        s_rd, s_dv;
    logic [31:0] s_addr, s_pc, s_instr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a + 32'h0000_0100;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input logic r, input logic dr, input logic rd, input logic [31:0] rpc,
                           input logic sp, input logic cdv, input logic cz, input logic erd,
                           input logic [31:0] ea, input logic edv, input logic [31:0] ep);
        vec_t v;
        v.r = r; v.dr = dr; v.rd = rd; v.rpc = rpc; v.spur = sp; v.cdv = cdv; v.cz = cz;
        v.erd = erd; v.ea = ea; v.edv = edv; v.ep = ep;
        vecs.push_back(v);
    endtask

    // One clock cycle: drive inputs and memory response, sample at negedge, score deliveries.
    task automatic run_cycle(input logic r, input logic dr, input logic rd,
                             input logic [31:0] rpc, input logic spur);
        logic [31:0] e;
        rst               = r;
        fu_if.dec_ready   = dr;
        fu_if.redirect    = rd;
        fu_if.redirect_pc = rpc;
        if (mem_pend) begin
            fu_if.imem_ready = 1'b1;
            fu_if.imem_instr = mem_data;
        end else if (spur) begin
            fu_if.imem_ready = 1'b1;
            fu_if.imem_instr = 32'hDEAD_BEEF;
        end else begin
            fu_if.imem_ready = 1'b0;
        end
        @(negedge clk);
        s_rd    = fu_if.imem_rd_en;
        s_addr  = fu_if.imem_addr;
        s_dv    = fu_if.dec_valid;
        s_pc    = fu_if.dec_pc;
        s_instr = fu_if.dec_instr;
        check32("count_le_2", {31'd0, (dut.count_q > 2'd2)}, 32'd0);
        if (r) begin
            exp_q.delete();
            exp_q.push_back(RESET_PC);
        end else if (rd) begin
            exp_q.delete();
            exp_q.push_back(rpc);
        end else if (s_dv && dr) begin
            e = exp_q.pop_front();
            check32("sb_pc", s_pc, e);
            check32("sb_instr", s_instr, mem_word(e));
            exp_q.push_back(e + 32'd1);
            delivered++;
        end
        mem_pend = s_rd;
        mem_data = mem_word(s_addr);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst               = 1'b1;
        fu_if.dec_ready   = 1'b0;
        fu_if.redirect    = 1'b0;
        fu_if.redirect_pc = 32'h0000_0000;
        fu_if.imem_ready  = 1'b0;
        fu_if.imem_instr  = 32'h0000_0000;
        mem_pend          = 1'b0;
        mem_data          = 32'h0000_0000;
        exp_q.push_back(RESET_PC);

        //       r     dr    rd    rpc            sp    cdv   cz    erd   ea             edv   ep
        add_vec(1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0);
        add_vec(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b1, 32'h0,         1'b0, 32'h0);
        add_vec(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b1, 32'h1,         1'b0, 32'h0);
        add_vec(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 32'h2,         1'b1, 32'h0);
        add_vec(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 32'h3,         1'b1, 32'h1);
        // decode stalls for five cycles; a spurious ready with nothing in flight is injected
        add_vec(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'h4,         1'b1, 32'h2);
        add_vec(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 32'h4,         1'b1, 32'h2);
        add_vec(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'h4,         1'b1, 32'h2);
        add_vec(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'h4,         1'b1, 32'h2);
        add_vec(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'h4,         1'b1, 32'h2);
        add_vec(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 32'h4,         1'b1, 32'h2);
        add_vec(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 32'h5,         1'b1, 32'h3);
        add_vec(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 32'h6,         1'b1, 32'h4);
        // redirect to 0x40 while the response for pc 6 arrives
        add_vec(1'b0, 1'b1, 1'b1, 32'h40,        1'b0, 1'b1, 1'b0, 1'b0, 32'h7,         1'b1, 32'h5);
        add_vec(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b1, 32'h40,        1'b0, 32'h0);
        add_vec(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 32'h41,        1'b0, 32'h0);
        add_vec(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 32'h42,        1'b1, 32'h40);
        add_vec(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 32'h43,        1'b1, 32'h41);
        // redirect to the top of the address space to exercise PC wrap
        add_vec(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0, 32'h44,        1'b1, 32'h42);
        add_vec(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0);
        add_vec(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 32'h0,         1'b0, 32'h0);
        add_vec(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 32'h1,         1'b1, 32'hFFFF_FFFF);
        add_vec(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 32'h2,         1'b1, 32'h0);
        add_vec(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 32'h3,         1'b1, 32'h1);
        // one-cycle reset with a buffered entry and a response in flight
        add_vec(1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h4,         1'b0, 32'h0);
        add_vec(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b1, 32'h0,         1'b0, 32'h0);
        add_vec(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b1, 32'h1,         1'b0, 32'h0);
        add_vec(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 32'h2,         1'b1, 32'h0);
        add_vec(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 32'h3,         1'b1, 32'h1);

        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_cycle(vecs[i].r, vecs[i].dr, vecs[i].rd, vecs[i].rpc, vecs[i].spur);
            check32($sformatf("v%0d_rd_en", i), {31'd0, s_rd}, {31'd0, vecs[i].erd});
            check32($sformatf("v%0d_addr", i), s_addr, vecs[i].ea);
            if (vecs[i].cdv) begin
                check32($sformatf("v%0d_dec_valid", i), {31'd0, s_dv}, {31'd0, vecs[i].edv});
            end
            if (vecs[i].cdv && vecs[i].edv) begin
                check32($sformatf("v%0d_dec_pc", i), s_pc, vecs[i].ep);
                check32($sformatf("v%0d_dec_instr", i), s_instr, mem_word(vecs[i].ep));
            end
            if (vecs[i].cz) begin
                check32($sformatf("v%0d_pc_zero", i), s_pc, 32'h0);
                check32($sformatf("v%0d_instr_zero", i), s_instr, 32'h0);
            end
        end

        delivered = 0;
        for (int n = 0; n < 10000; n++) begin
            logic        r_v, rd_v, sp_v;
            logic [31:0] rpc_v;
            r_v   = ($urandom_range(0, 499) == 0);
            rd_v  = ($urandom_range(0, 49) == 0);
            sp_v  = ($urandom_range(0, 7) == 0);
            rpc_v = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
            run_cycle(r_v, 1'($urandom_range(0, 1)), rd_v, rpc_v, sp_v);
        end
        check32("random_liveness", {31'd0, (delivered >= 2000)}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
